// File: rtl/pipe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, mul/div op codes,
// mul/div sequencer states and a small op-decode helper.
package pipe_pkg;

   // Number of iterations of the mul/div unit (one bit per cycle)
   localparam int MD_CYCLES = 32;
   localparam logic [4:0] MD_CNT_START = 5'(MD_CYCLES - 1);

   // ALU opcodes
   localparam logic [3:0] ALU_ADDU = 4'd0;
   localparam logic [3:0] ALU_SUBU = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   // Mul/div op codes
   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MFHI  = 3'd5;
   localparam logic [2:0] MD_MFLO  = 3'd6;

   // Mul/div sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   // True for the ops that launch an iterative mul/div
   function automatic logic is_md_start_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative 32-step multiply / restoring-divide datapath. Works on operand
// magnitudes and applies the sign correction to the final step's value, so
// the 64-bit result is valid in the same cycle that out_done is high.
module md_iter
   import pipe_pkg::*;
(
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_start,
   input  logic        in_step,
   input  logic        in_is_div,
   input  logic        in_signed,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_done,
   output logic [63:0] out_result
);

   // acc holds {HI,LO} partial product for mul, {remainder,quotient} for div
   logic [63:0] acc_q, acc_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        div0_q, div0_d;

   logic        a_neg_s, b_neg_s;
   logic [31:0] a_mag_s, b_mag_s;
   logic [32:0] mul_sum_s, div_shift_s, div_diff_s;
   logic [63:0] step_s;
   logic [31:0] quo_s, rem_s;

   // Operand capture, one iteration step and final sign correction
   always_comb begin
      acc_d     = acc_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;

      a_neg_s = in_signed & in_a[31];
      b_neg_s = in_signed & in_b[31];
      a_mag_s = a_neg_s ? (32'd0 - in_a) : in_a;
      b_mag_s = b_neg_s ? (32'd0 - in_b) : in_b;

      // Shift-add: add multiplicand to the upper half when the LSB is set
      if (acc_q[0]) begin
         mul_sum_s = {1'b0, acc_q[63:32]} + {1'b0, b_q};
      end else begin
         mul_sum_s = {1'b0, acc_q[63:32]};
      end

      // Restoring divide: the borrow lands in bit 32 when the trial fails
      div_shift_s = acc_q[63:31];
      div_diff_s  = div_shift_s - {1'b0, b_q};

      if (is_div_q) begin
         if (!div_diff_s[32]) begin
            step_s = {div_diff_s[31:0], acc_q[30:0], 1'b1};
         end else begin
            step_s = {acc_q[62:31], acc_q[30:0], 1'b0};
         end
      end else begin
         step_s = {mul_sum_s, acc_q[31:1]};
      end

      if (in_start) begin
         acc_d     = {32'd0, a_mag_s};
         b_d       = b_mag_s;
         cnt_d     = MD_CNT_START;
         is_div_d  = in_is_div;
         neg_res_d = a_neg_s ^ b_neg_s;
         neg_rem_d = a_neg_s;
         div0_d    = (in_b == 32'd0);
      end else if (in_step) begin
         acc_d = step_s;
         cnt_d = cnt_q - 5'd1;
      end else begin
         acc_d = acc_q;
      end

      out_done = in_step && (cnt_q == 5'd0);

      // Divide by zero keeps the dividend in HI (the remainder restores to it)
      quo_s = step_s[31:0];
      rem_s = step_s[63:32];
      if (is_div_q) begin
         out_result[31:0]  = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? (32'd0 - quo_s) : quo_s);
         out_result[63:32] = neg_rem_q ? (32'd0 - rem_s) : rem_s;
      end else begin
         out_result = neg_res_q ? (64'd0 - step_s) : step_s;
      end
   end

   // Datapath registers
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         acc_q     <= 64'd0;
         b_q       <= 32'd0;
         cnt_q     <= 5'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
      end
   end

endmodule

// File: rtl/pipe_ex_stage.sv
// Execute stage: single-cycle ALU, HI/LO pair, iterative mul/div sequencer
// and the EX/MEM pipeline register. out_busy freezes the front of the pipe
// while a mul/div occupies EX; EX/MEM receives bubbles during that time.
module pipe_ex_stage
   import pipe_pkg::*;
(
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_dmem_ena,
   input  logic        in_dmem_wena,
   input  logic [1:0]  in_dmem_type,
   input  logic [31:0] in_rs_data,
   input  logic [31:0] in_rt_data,
   input  logic [4:0]  in_rd_waddr,
   input  logic        in_rd_sel,
   input  logic        in_rd_wena,
   input  logic [31:0] in_immed,
   input  logic [31:0] in_shamt,
   input  logic        in_alu_a_sel,
   input  logic        in_alu_b_sel,
   input  logic [3:0]  in_alu_sel,
   input  logic [2:0]  in_md_op,
   output logic        out_busy,
   output logic        out_dmem_ena,
   output logic        out_dmem_wena,
   output logic [1:0]  out_dmem_type,
   output logic [31:0] out_alu_result,
   output logic [31:0] out_rt_data,
   output logic [4:0]  out_rd_waddr,
   output logic        out_rd_sel,
   output logic        out_rd_wena
);

   logic [31:0] alu_a_s, alu_b_s, alu_res_s, ex_res_s;

   md_state_e   state_q, state_d;
   logic        md_start_s, md_step_s, md_done_s, md_is_div_s, md_signed_s, busy_s;
   logic [63:0] md_result_s;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   logic        dmem_ena_q, dmem_ena_d;
   logic        dmem_wena_q, dmem_wena_d;
   logic [1:0]  dmem_type_q, dmem_type_d;
   logic [31:0] alu_result_q, alu_result_d;
   logic [31:0] rt_data_q, rt_data_d;
   logic [4:0]  rd_waddr_q, rd_waddr_d;
   logic        rd_sel_q, rd_sel_d;
   logic        rd_wena_q, rd_wena_d;

   // Operand select and single-cycle ALU
   always_comb begin
      alu_a_s = in_alu_a_sel ? in_shamt : in_rs_data;
      alu_b_s = in_alu_b_sel ? in_immed : in_rt_data;
      case (in_alu_sel)
         ALU_ADDU: alu_res_s = alu_a_s + alu_b_s;
         ALU_SUBU: alu_res_s = alu_a_s - alu_b_s;
         ALU_AND:  alu_res_s = alu_a_s & alu_b_s;
         ALU_OR:   alu_res_s = alu_a_s | alu_b_s;
         ALU_XOR:  alu_res_s = alu_a_s ^ alu_b_s;
         ALU_NOR:  alu_res_s = ~(alu_a_s | alu_b_s);
         ALU_SLT:  alu_res_s = ($signed(alu_a_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
         ALU_SLTU: alu_res_s = (alu_a_s < alu_b_s) ? 32'd1 : 32'd0;
         ALU_SLL:  alu_res_s = alu_b_s << alu_a_s[4:0];
         ALU_SRL:  alu_res_s = alu_b_s >> alu_a_s[4:0];
         ALU_SRA:  alu_res_s = $unsigned($signed(alu_b_s) >>> alu_a_s[4:0]);
         ALU_LUI:  alu_res_s = {alu_b_s[15:0], 16'h0000};
         default:  alu_res_s = 32'd0;
      endcase
   end

   // Mul/div sequencer: next state and stall request
   always_comb begin
      md_start_s  = (state_q == ST_IDLE) && is_md_start_op(in_md_op);
      md_step_s   = (state_q == ST_RUN);
      md_is_div_s = (in_md_op == MD_DIV) || (in_md_op == MD_DIVU);
      md_signed_s = (in_md_op == MD_MULT) || (in_md_op == MD_DIV);
      // Reset drops the stall immediately, even while the op is still presented
      busy_s      = !in_rst && (md_start_s || md_step_s);
      state_d     = state_q;
      case (state_q)
         ST_IDLE: begin
            if (md_start_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (md_done_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign out_busy = busy_s;

   md_iter u_md_iter (
      .in_clk     (in_clk),
      .in_rst     (in_rst),
      .in_start   (md_start_s),
      .in_step    (md_step_s),
      .in_is_div  (md_is_div_s),
      .in_signed  (md_signed_s),
      .in_a       (in_rs_data),
      .in_b       (in_rt_data),
      .out_done   (md_done_s),
      .out_result (md_result_s)
   );

   // HI/LO update on the final iteration edge, so DONE and the next
   // instruction already see the new values
   always_comb begin
      if (md_done_s) begin
         hi_d = md_result_s[63:32];
         lo_d = md_result_s[31:0];
      end else begin
         hi_d = hi_q;
         lo_d = lo_q;
      end
   end

   // Result mux and EX/MEM next value (bubble while stalled)
   always_comb begin
      case (in_md_op)
         MD_MFHI: ex_res_s = hi_q;
         MD_MFLO: ex_res_s = lo_q;
         default: ex_res_s = alu_res_s;
      endcase
      if (busy_s) begin
         dmem_ena_d   = 1'b0;
         dmem_wena_d  = 1'b0;
         dmem_type_d  = 2'd0;
         alu_result_d = 32'd0;
         rt_data_d    = 32'd0;
         rd_waddr_d   = 5'd0;
         rd_sel_d     = 1'b0;
         rd_wena_d    = 1'b0;
      end else begin
         dmem_ena_d   = in_dmem_ena;
         dmem_wena_d  = in_dmem_wena;
         dmem_type_d  = in_dmem_type;
         alu_result_d = ex_res_s;
         rt_data_d    = in_rt_data;
         rd_waddr_d   = in_rd_waddr;
         rd_sel_d     = in_rd_sel;
         rd_wena_d    = in_rd_wena;
      end
   end

   // State, HI/LO and EX/MEM registers
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q      <= ST_IDLE;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         dmem_ena_q   <= 1'b0;
         dmem_wena_q  <= 1'b0;
         dmem_type_q  <= 2'd0;
         alu_result_q <= 32'd0;
         rt_data_q    <= 32'd0;
         rd_waddr_q   <= 5'd0;
         rd_sel_q     <= 1'b0;
         rd_wena_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         dmem_ena_q   <= dmem_ena_d;
         dmem_wena_q  <= dmem_wena_d;
         dmem_type_q  <= dmem_type_d;
         alu_result_q <= alu_result_d;
         rt_data_q    <= rt_data_d;
         rd_waddr_q   <= rd_waddr_d;
         rd_sel_q     <= rd_sel_d;
         rd_wena_q    <= rd_wena_d;
      end
   end

   assign out_dmem_ena   = dmem_ena_q;
   assign out_dmem_wena  = dmem_wena_q;
   assign out_dmem_type  = dmem_type_q;
   assign out_alu_result = alu_result_q;
   assign out_rt_data    = rt_data_q;
   assign out_rd_waddr   = rd_waddr_q;
   assign out_rd_sel     = rd_sel_q;
   assign out_rd_wena    = rd_wena_q;

endmodule

// File: tb/tb_pipe_ex_stage.sv
// Scoreboard bench for pipe_ex_stage: the driver pushes one expected entry
// per issued cycle (stall flag during the cycle, EX/MEM contents after it);
// the monitor pops and compares on the falling edges.
module tb_pipe_ex_stage;
   import pipe_pkg::*;

   logic        in_clk = 1'b0;
   logic        in_rst;
   logic        in_dmem_ena, in_dmem_wena;
   logic [1:0]  in_dmem_type;
   logic [31:0] in_rs_data, in_rt_data, in_immed, in_shamt;
   logic [4:0]  in_rd_waddr;
   logic        in_rd_sel, in_rd_wena, in_alu_a_sel, in_alu_b_sel;
   logic [3:0]  in_alu_sel;
   logic [2:0]  in_md_op;
   logic        out_busy, out_dmem_ena, out_dmem_wena, out_rd_sel, out_rd_wena;
   logic [1:0]  out_dmem_type;
   logic [31:0] out_alu_result, out_rt_data;
   logic [4:0]  out_rd_waddr;

   typedef struct {
      logic de, dw;
      logic [1:0] dt;
      logic [31:0] rs, rt, imm, sh;
      logic [4:0] wa;
      logic rsel, wen, as, bs;
      logic [3:0] alu;
      logic [2:0] md;
   } stim_t;

   typedef struct {
      string tag;
      logic busy;
      logic [31:0] res;
      logic [31:0] rt;
      logic [10:0] ctl;
   } exp_t;

   exp_t  exq[$];
   int    total = 0;
   int    bad = 0;
   logic  mon_en = 1'b0;

   pipe_ex_stage dut (
      .in_clk(in_clk), .in_rst(in_rst),
      .in_dmem_ena(in_dmem_ena), .in_dmem_wena(in_dmem_wena), .in_dmem_type(in_dmem_type),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_rd_waddr(in_rd_waddr),
      .in_rd_sel(in_rd_sel), .in_rd_wena(in_rd_wena), .in_immed(in_immed), .in_shamt(in_shamt),
      .in_alu_a_sel(in_alu_a_sel), .in_alu_b_sel(in_alu_b_sel), .in_alu_sel(in_alu_sel),
      .in_md_op(in_md_op), .out_busy(out_busy),
      .out_dmem_ena(out_dmem_ena), .out_dmem_wena(out_dmem_wena), .out_dmem_type(out_dmem_type),
      .out_alu_result(out_alu_result), .out_rt_data(out_rt_data), .out_rd_waddr(out_rd_waddr),
      .out_rd_sel(out_rd_sel), .out_rd_wena(out_rd_wena)
   );

   always #5 in_clk = ~in_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic stim_t nop();
      stim_t s;
      s.de = 1'b0; s.dw = 1'b0; s.dt = 2'd0;
      s.rs = 32'd0; s.rt = 32'd0; s.imm = 32'd0; s.sh = 32'd0;
      s.wa = 5'd0; s.rsel = 1'b0; s.wen = 1'b0; s.as = 1'b0; s.bs = 1'b0;
      s.alu = ALU_ADDU; s.md = MD_NONE;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      in_dmem_ena = s.de; in_dmem_wena = s.dw; in_dmem_type = s.dt;
      in_rs_data = s.rs; in_rt_data = s.rt; in_immed = s.imm; in_shamt = s.sh;
      in_rd_waddr = s.wa; in_rd_sel = s.rsel; in_rd_wena = s.wen;
      in_alu_a_sel = s.as; in_alu_b_sel = s.bs; in_alu_sel = s.alu; in_md_op = s.md;
   endtask

   // Drive one cycle of stimulus and record what must come out of it
   task automatic issue(input stim_t s, input logic [31:0] exp_res, input logic exp_busy,
                        input string tag);
      exp_t e;
      @(posedge in_clk);
      #1;
      apply(s);
      e.tag  = tag;
      e.busy = exp_busy;
      if (exp_busy) begin
         e.res = 32'd0; e.rt = 32'd0; e.ctl = 11'd0;
      end else begin
         e.res = exp_res; e.rt = s.rt;
         e.ctl = {s.de, s.dw, s.dt, s.wa, s.rsel, s.wen};
      end
      exq.push_back(e);
   endtask

   // Full mul/div occupancy: 1 IDLE + 32 RUN stalled cycles, then DONE passes
   task automatic md_run(input stim_t s, input logic [31:0] done_res, input string tag);
      issue(s, 32'd0, 1'b1, tag);
      repeat (32) issue(s, 32'd0, 1'b1, tag);
      issue(s, done_res, 1'b0, {tag, "_done"});
   endtask

   task automatic do_reset();
      @(posedge in_clk);
      #1;
      in_rst = 1'b1;
      apply(nop());
      mon_en = 1'b0;
      exq.delete();
      #1;
      chk("rst_busy", 32'(out_busy), 32'd0);
      chk("rst_result", out_alu_result, 32'd0);
      chk("rst_rt_data", out_rt_data, 32'd0);
      chk("rst_ctl", 32'({out_dmem_ena, out_dmem_wena, out_dmem_type, out_rd_waddr,
                          out_rd_sel, out_rd_wena}), 32'd0);
      repeat (2) @(posedge in_clk);
      #1;
      in_rst = 1'b0;
      mon_en = 1'b1;
   endtask

   // Monitor: pop an entry each falling edge, compare it one cycle later
   initial begin
      exp_t cur;
      logic pend;
      logic busy_seen;
      pend = 1'b0;
      busy_seen = 1'b0;
      forever begin
         @(negedge in_clk);
         if (!mon_en) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               chk({cur.tag, "_busy"}, 32'(busy_seen), 32'(cur.busy));
               chk({cur.tag, "_result"}, out_alu_result, cur.res);
               chk({cur.tag, "_rt_data"}, out_rt_data, cur.rt);
               chk({cur.tag, "_ctl"}, 32'({out_dmem_ena, out_dmem_wena, out_dmem_type,
                                           out_rd_waddr, out_rd_sel, out_rd_wena}),
                   32'(cur.ctl));
            end
            if (exq.size() > 0) begin
               cur = exq.pop_front();
               busy_seen = out_busy;
               pend = 1'b1;
            end else begin
               pend = 1'b0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached with %0d entries pending", exq.size());
      $fatal(1, "time limit");
   end

   initial begin
      stim_t s;
      in_rst = 1'b1;
      apply(nop());
      do_reset();

      // Plain ALU ops
      s = nop(); s.wen = 1'b1; s.wa = 5'd3;
      s.rs = 32'h7FFF_FFFF; s.rt = 32'd1;
      issue(s, 32'h8000_0000, 1'b0, "addu");
      s.alu = ALU_SRA; s.as = 1'b1; s.sh = 32'd4; s.rt = 32'hF000_0000;
      issue(s, 32'hFF00_0000, 1'b0, "sra");
      s.alu = ALU_SLT; s.as = 1'b0; s.rs = 32'hFFFF_FFFF; s.rt = 32'd1;
      issue(s, 32'd1, 1'b0, "slt");
      s.alu = ALU_SLTU;
      issue(s, 32'd0, 1'b0, "sltu");
      s.alu = ALU_SUBU; s.rs = 32'd5; s.rt = 32'd7; s.rsel = 1'b1;
      issue(s, 32'hFFFF_FFFE, 1'b0, "subu");
      s.alu = ALU_LUI; s.bs = 1'b1; s.imm = 32'h0000_1234; s.rsel = 1'b0;
      issue(s, 32'h1234_0000, 1'b0, "lui");
      s.alu = ALU_NOR; s.bs = 1'b0; s.rs = 32'd0; s.rt = 32'd0;
      issue(s, 32'hFFFF_FFFF, 1'b0, "nor");
      s.alu = ALU_SLL; s.as = 1'b1; s.sh = 32'd31; s.rt = 32'd1;
      issue(s, 32'h8000_0000, 1'b0, "sll31");
      s.alu = ALU_SRL; s.sh = 32'd1; s.rt = 32'h8000_0000;
      issue(s, 32'h4000_0000, 1'b0, "srl");

      // Store-style pass-through
      s = nop(); s.de = 1'b1; s.dw = 1'b1; s.dt = 2'b10; s.bs = 1'b1;
      s.rs = 32'h0000_0100; s.imm = 32'd4; s.rt = 32'hDEAD_BEEF;
      issue(s, 32'h0000_0104, 1'b0, "sw");

      // MULT -3 * 7, then read back LO/HI immediately
      s = nop(); s.md = MD_MULT; s.rs = 32'hFFFF_FFFD; s.rt = 32'd7;
      md_run(s, 32'd4, "mult");
      s = nop(); s.md = MD_MFLO; s.wen = 1'b1; s.wa = 5'd9;
      issue(s, 32'hFFFF_FFEB, 1'b0, "mult_mflo");
      s.md = MD_MFHI;
      issue(s, 32'hFFFF_FFFF, 1'b0, "mult_mfhi");

      // DIV -7 / 2
      s = nop(); s.md = MD_DIV; s.rs = 32'hFFFF_FFF9; s.rt = 32'd2;
      md_run(s, 32'hFFFF_FFFB, "div");
      s = nop(); s.md = MD_MFLO; s.wen = 1'b1; s.wa = 5'd10;
      issue(s, 32'hFFFF_FFFD, 1'b0, "div_mflo");
      s.md = MD_MFHI;
      issue(s, 32'hFFFF_FFFF, 1'b0, "div_mfhi");

      // DIVU 100 / 0
      s = nop(); s.md = MD_DIVU; s.rs = 32'd100; s.rt = 32'd0;
      md_run(s, 32'd100, "divu0");
      s = nop(); s.md = MD_MFLO; s.wen = 1'b1; s.wa = 5'd11;
      issue(s, 32'hFFFF_FFFF, 1'b0, "divu0_mflo");
      s.md = MD_MFHI;
      issue(s, 32'd100, 1'b0, "divu0_mfhi");

      // Reset in the middle of a MULT: HI/LO must come back cleared
      s = nop(); s.md = MD_MULT; s.rs = 32'hFFFF_FFFD; s.rt = 32'd7;
      issue(s, 32'd0, 1'b1, "abort");
      repeat (10) issue(s, 32'd0, 1'b1, "abort");
      do_reset();
      s = nop(); s.md = MD_MFHI; s.wen = 1'b1; s.wa = 5'd12;
      issue(s, 32'd0, 1'b0, "abort_mfhi");
      s.md = MD_MFLO;
      issue(s, 32'd0, 1'b0, "abort_mflo");

      // MULTU 5 * 6 after the abort
      s = nop(); s.md = MD_MULTU; s.rs = 32'd5; s.rt = 32'd6;
      md_run(s, 32'd11, "multu");
      s = nop(); s.md = MD_MFLO; s.wen = 1'b1; s.wa = 5'd13;
      issue(s, 32'd30, 1'b0, "multu_mflo");
      s.md = MD_MFHI;
      issue(s, 32'd0, 1'b0, "multu_mfhi");

      issue(nop(), 32'd0, 1'b0, "tail");
      repeat (2) @(negedge in_clk);
      #1;
      chk("queue_drained", 32'(exq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
